// File: rtl/hms_timer.sv
// Hours/minutes/seconds timekeeper with a CLK_HZ prescaler, up/down counting,
// field adjust with optional carry, preset load and registered event pulses.
module hms_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int HOURS_MAX = 23,
  parameter int ADJ_CARRY = 0,
  localparam int HW       = $clog2(HOURS_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          count_down,
  input  logic [1:0]    sel,
  input  logic          plus,
  input  logic          minus,
  input  logic          load,
  input  logic [HW-1:0] load_h,
  input  logic [5:0]    load_m,
  input  logic [5:0]    load_s,
  output logic [HW-1:0] hours,
  output logic [5:0]    mins,
  output logic [5:0]    secs,
  output logic          sec_tick,
  output logic          rollover,
  output logic          expired,
  output logic          zero
);

  localparam int             PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  P_MAX = PW'(CLK_HZ - 1);
  localparam logic [HW-1:0]  H_MAX = HW'(HOURS_MAX);

  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] hours_q, hours_d;
  logic [5:0]    mins_q, mins_d;
  logic [5:0]    secs_q, secs_d;
  logic          tick_q, tick_d;
  logic          roll_q, roll_d;
  logic          exp_q, exp_d;
  logic          zero_q, zero_d;

  logic          step_req;
  logic          adj_ok;
  logic          dir_up;
  logic [HW-1:0] h_new;
  logic [5:0]    m_new, s_new;
  logic          h_wr, m_wr, s_wr;
  logic          at_max;

  assign step_req = run && (presc_q == P_MAX);
  assign adj_ok   = (plus ^ minus) && (sel != 2'b00);
  // One +/-1 datapath serves both adjust (direction from plus) and step.
  assign dir_up   = adj_ok ? plus : !count_down;

  assign s_wr  = dir_up ? (secs_q == 6'd59) : (secs_q == 6'd0);
  assign m_wr  = dir_up ? (mins_q == 6'd59) : (mins_q == 6'd0);
  assign h_wr  = dir_up ? (hours_q == H_MAX) : (hours_q == '0);
  assign s_new = s_wr ? (dir_up ? 6'd0 : 6'd59) : (dir_up ? secs_q + 6'd1 : secs_q - 6'd1);
  assign m_new = m_wr ? (dir_up ? 6'd0 : 6'd59) : (dir_up ? mins_q + 6'd1 : mins_q - 6'd1);
  assign h_new = h_wr ? (dir_up ? '0 : H_MAX)
                      : (dir_up ? hours_q + HW'(1) : hours_q - HW'(1));
  assign at_max = (secs_q == 6'd59) && (mins_q == 6'd59) && (hours_q == H_MAX);

  always_comb begin
    presc_d = presc_q;
    hours_d = hours_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    tick_d  = 1'b0;
    roll_d  = 1'b0;
    exp_d   = 1'b0;
    if (load) begin
      presc_d = '0;
      hours_d = (load_h > H_MAX) ? H_MAX : load_h;
      mins_d  = (load_m > 6'd59) ? 6'd59 : load_m;
      secs_d  = (load_s > 6'd59) ? 6'd59 : load_s;
    end else if (adj_ok) begin
      presc_d = '0;
      case (sel)
        2'b01: begin
          secs_d = s_new;
          if ((ADJ_CARRY != 0) && s_wr) begin
            mins_d = m_new;
            if (m_wr) hours_d = h_new;
          end
        end
        2'b10: begin
          mins_d = m_new;
          if ((ADJ_CARRY != 0) && m_wr) hours_d = h_new;
        end
        default: hours_d = h_new;
      endcase
    end else if (run) begin
      if (step_req) begin
        presc_d = '0;
        // Counting down stops at 0:00:00; the request is consumed without effect.
        if (!(count_down && zero_q)) begin
          tick_d = 1'b1;
          secs_d = s_new;
          if (s_wr) begin
            mins_d = m_new;
            if (m_wr) hours_d = h_new;
          end
          roll_d = !count_down && at_max;
          exp_d  = count_down && (hours_q == '0) && (mins_q == 6'd0) && (secs_q == 6'd1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    zero_d = (hours_d == '0) && (mins_d == 6'd0) && (secs_d == 6'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      hours_q <= '0;
      mins_q  <= '0;
      secs_q  <= '0;
      tick_q  <= 1'b0;
      roll_q  <= 1'b0;
      exp_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      presc_q <= presc_d;
      hours_q <= hours_d;
      mins_q  <= mins_d;
      secs_q  <= secs_d;
      tick_q  <= tick_d;
      roll_q  <= roll_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
    end
  end

  assign hours    = hours_q;
  assign mins     = mins_q;
  assign secs     = secs_q;
  assign sec_tick = tick_q;
  assign rollover = roll_q;
  assign expired  = exp_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_hms_timer.sv
// Directed bench for hms_timer (CLK_HZ=4, HOURS_MAX=23): a vector table for
// counting/load behaviour plus hand sequences for adjust and reset corners.
module tb_hms_timer;

  logic       clk = 1'b0;
  logic       reset, run, count_down, plus, minus, load;
  logic [1:0] sel;
  logic [4:0] load_h;
  logic [5:0] load_m, load_s;

  logic [4:0] h0, h1;
  logic [5:0] m0, s0, m1, s1;
  logic       t0, r0, e0, z0, t1, r1, e1, z1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hms_timer #(.CLK_HZ(4), .HOURS_MAX(23), .ADJ_CARRY(0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .count_down(count_down), .sel(sel),
    .plus(plus), .minus(minus), .load(load), .load_h(load_h), .load_m(load_m),
    .load_s(load_s), .hours(h0), .mins(m0), .secs(s0), .sec_tick(t0),
    .rollover(r0), .expired(e0), .zero(z0)
  );

  hms_timer #(.CLK_HZ(4), .HOURS_MAX(23), .ADJ_CARRY(1)) dut1 (
    .clk(clk), .reset(reset), .run(run), .count_down(count_down), .sel(sel),
    .plus(plus), .minus(minus), .load(load), .load_h(load_h), .load_m(load_m),
    .load_s(load_s), .hours(h1), .mins(m1), .secs(s1), .sec_tick(t1),
    .rollover(r1), .expired(e1), .zero(z1)
  );

  typedef struct {
    logic       rst, run, cd, ld;
    logic [4:0] lh;
    logic [5:0] lm, ls;
    logic [4:0] eh;
    logic [5:0] em, es;
    logic       et, er, ex, ez;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_i, run_i, cd_i, ld_i,
                     input logic [4:0] lh_i, input logic [5:0] lm_i, ls_i,
                     input logic [4:0] eh_i, input logic [5:0] em_i, es_i,
                     input logic et_i, er_i, ex_i, ez_i);
    vec_t v;
    v.rst = rst_i; v.run = run_i; v.cd = cd_i; v.ld = ld_i;
    v.lh = lh_i; v.lm = lm_i; v.ls = ls_i;
    v.eh = eh_i; v.em = em_i; v.es = es_i;
    v.et = et_i; v.er = er_i; v.ex = ex_i; v.ez = ez_i;
    vq.push_back(v);
  endtask

  // n quiet cycles with a fixed expected time and no pulses
  task automatic idle(input int n, input logic run_i, cd_i,
                      input logic [4:0] eh_i, input logic [5:0] em_i, es_i, input logic ez_i);
    for (int i = 0; i < n; i++)
      add(1'b0, run_i, cd_i, 1'b0, 5'd0, 6'd0, 6'd0, eh_i, em_i, es_i, 1'b0, 1'b0, 1'b0, ez_i);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    reset = 1'b0; load = 1'b0; plus = 1'b0; minus = 1'b0; sel = 2'b00;
    load_h = '0; load_m = '0; load_s = '0;
  endtask

  initial begin
    clr_in();
    run = 1'b0; count_down = 1'b0;

    // Reset, then count up from zero; run pauses keep the partial second.
    add(1, 1, 0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 1);
    idle(3, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 1,   1, 0, 0, 0);
    idle(1, 1, 0, 0, 0, 1, 0);
    idle(2, 0, 0, 0, 0, 1, 0);
    idle(2, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 2,   1, 0, 0, 0);
    // Rollover from 23:59:59
    add(0, 1, 0, 1, 23, 59, 58, 23, 59, 58, 0, 0, 0, 0);
    idle(3, 1, 0, 23, 59, 58, 0);
    add(0, 1, 0, 0, 0, 0, 0,   23, 59, 59, 1, 0, 0, 0);
    idle(3, 1, 0, 23, 59, 59, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0,   1, 1, 0, 1);
    idle(1, 1, 0, 0, 0, 0, 1);
    // Count down, borrow, expiry, then hold at zero
    add(0, 1, 1, 1, 0, 1, 0,   0, 1, 0,   0, 0, 0, 0);
    idle(3, 1, 1, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0,   0, 0, 59,  1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, 1,   0, 0, 1,   0, 0, 0, 0);
    idle(3, 1, 1, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0,   0, 0, 0,   1, 0, 1, 1);
    idle(7, 1, 1, 0, 0, 0, 1);
    // Out-of-range load saturation
    add(0, 0, 0, 1, 0, 0, 63,  0, 0, 59,  0, 0, 0, 0);
    add(0, 0, 0, 1, 31, 60, 5, 23, 59, 5, 0, 0, 0, 0);

    foreach (vq[i]) begin
      reset = vq[i].rst; run = vq[i].run; count_down = vq[i].cd; load = vq[i].ld;
      load_h = vq[i].lh; load_m = vq[i].lm; load_s = vq[i].ls;
      cyc();
      chk($sformatf("vec%0d", i), {h0, m0, s0, t0, r0, e0, z0},
          {vq[i].eh, vq[i].em, vq[i].es, vq[i].et, vq[i].er, vq[i].ex, vq[i].ez});
    end
    clr_in();
    run = 1'b0; count_down = 1'b0;

    // Adjust wrap with and without carry
    load = 1; load_h = 0; load_m = 5; load_s = 59; cyc(); clr_in();
    sel = 2'b01; plus = 1; cyc(); clr_in();
    chk("adj_plus_nocarry", {h0, m0, s0}, {5'd0, 6'd5, 6'd0});
    chk("adj_plus_carry",   {h1, m1, s1}, {5'd0, 6'd6, 6'd0});
    sel = 2'b01; minus = 1; cyc(); clr_in();
    chk("adj_minus_nocarry", {h0, m0, s0}, {5'd0, 6'd5, 6'd59});
    chk("adj_minus_carry",   {h1, m1, s1}, {5'd0, 6'd5, 6'd59});
    load = 1; load_h = 23; cyc(); clr_in();
    sel = 2'b11; plus = 1; cyc(); clr_in();
    chk("adj_hour_wrap0", {h0, m0, s0, r0, e0, z0}, {5'd0, 6'd0, 6'd0, 3'b001});
    chk("adj_hour_wrap1", {h1, m1, s1, r1, e1, z1}, {5'd0, 6'd0, 6'd0, 3'b001});
    sel = 2'b01; minus = 1; cyc(); clr_in();
    chk("adj_borrow_nocarry", {h0, m0, s0}, {5'd0, 6'd0, 6'd59});
    chk("adj_borrow_carry",   {h1, m1, s1}, {5'd23, 6'd59, 6'd59});

    // Ignored adjusts (sel=00, plus&minus) leave the prescaler running
    load = 1; load_s = 10; cyc(); clr_in();
    run = 1; sel = 2'b00; plus = 1; cyc(); clr_in();
    cyc();
    sel = 2'b01; plus = 1; minus = 1; cyc(); clr_in();
    chk("both_no_change", {s0, t0}, {6'd10, 1'b0});
    cyc();
    chk("both_step_kept", {s0, t0}, {6'd11, 1'b1});

    // Adjust on the step-request cycle wins; next step 4 cycles later
    cyc(); cyc(); cyc();
    sel = 2'b01; plus = 1; cyc(); clr_in();
    chk("adj_on_step", {s0, t0}, {6'd12, 1'b0});
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("adj_wait%0d", i), {s0, t0}, {6'd12, 1'b0});
    end
    cyc();
    chk("adj_next_step", {s0, t0}, {6'd13, 1'b1});

    // Reset with load, adjust and a step request all in one cycle
    cyc(); cyc(); cyc();
    reset = 1; load = 1; load_h = 5; load_m = 5; load_s = 5; sel = 2'b01; plus = 1;
    cyc(); clr_in();
    chk("rst_over_all0", {h0, m0, s0, t0, r0, e0, z0}, {17'd0, 4'b0001});
    chk("rst_over_all1", {h1, m1, s1, t1, r1, e1, z1}, {17'd0, 4'b0001});
    cyc(); cyc(); cyc();
    chk("rst_wait", {s0, t0, z0}, {6'd0, 1'b0, 1'b1});
    cyc();
    chk("rst_first_step", {s0, t0, z0}, {6'd1, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
